// File: rtl/hd_mux_rr_if.sv
// Handshake bundle between N_CH upstream channels, the mux, and one downstream sink.
// The mux uses the slave view; the producer/consumer side uses the master view.
interface hd_mux_rr_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SELW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*WIDTH-1:0] a;
  logic [N_CH-1:0]       a_vld;
  logic [N_CH-1:0]       a_rdy;
  logic [SELW-1:0]       sl;
  logic [WIDTH-1:0]      z;
  logic                  z_vld;
  logic                  z_rdy;
  logic [SELW-1:0]       z_ch;

  modport master (
    output a, a_vld, sl, z_rdy,
    input  a_rdy, z, z_vld, z_ch
  );

  modport slave (
    input  a, a_vld, sl, z_rdy,
    output a_rdy, z, z_vld, z_ch
  );
endinterface

// File: rtl/hd_mux_rr.sv
// N-channel valid/ready mux with a one-deep registered output stage.
// Arbitration is round-robin, fixed lowest-index priority, or direct select via sl.
module hd_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0
) (
  input logic         clk,
  input logic         rst,
  hd_mux_rr_if.slave  bus
);
  localparam int SELW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [WIDTH-1:0] z_q;
  logic             z_vld_q;
  logic [SELW-1:0]  z_ch_q;
  logic [SELW-1:0]  ptr_q;

  logic             load_ok;
  logic             gnt_found;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;

  // The output register can take a new beat when empty or being drained this cycle.
  assign load_ok = !z_vld_q || bus.z_rdy;
  assign xfer    = !rst && load_ok && gnt_found;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    if (MODE == 2) begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.a_vld[i] && bus.sl == SELW'(i)) begin
          gnt_found = 1'b1;
          gnt_idx   = SELW'(i);
        end
      end
    end else begin
      // Round-robin: first scan channels at/above ptr, then wrap to the lowest.
      if (MODE == 0) begin
        for (int i = 0; i < N_CH; i++) begin
          if (!gnt_found && bus.a_vld[i] && SELW'(i) >= ptr_q) begin
            gnt_found = 1'b1;
            gnt_idx   = SELW'(i);
          end
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        if (!gnt_found && bus.a_vld[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_data  = '0;
    bus.a_rdy = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == SELW'(i)) begin
        gnt_data     = bus.a[i*WIDTH +: WIDTH];
        bus.a_rdy[i] = xfer;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q     <= '0;
      z_vld_q <= 1'b0;
      z_ch_q  <= '0;
      ptr_q   <= '0;
    end else if (xfer) begin
      z_q     <= gnt_data;
      z_ch_q  <= gnt_idx;
      z_vld_q <= 1'b1;
      if (MODE == 0) begin
        ptr_q <= (gnt_idx == SELW'(N_CH - 1)) ? '0 : gnt_idx + SELW'(1);
      end
    end else if (bus.z_rdy) begin
      z_vld_q <= 1'b0;
    end
  end

  assign bus.z     = z_q;
  assign bus.z_vld = z_vld_q;
  assign bus.z_ch  = z_ch_q;
endmodule

// File: tb/tb_hd_mux_rr.sv
// Bench for hd_mux_rr: four instances (RR/4, priority/4, direct/3, RR/1) checked
// against a transaction-level model, a directed vector table and hand sequences.
module tb_hd_mux_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hd_mux_rr_if #(.N_CH(4), .WIDTH(8)) if0 ();
  hd_mux_rr_if #(.N_CH(4), .WIDTH(8)) if1 ();
  hd_mux_rr_if #(.N_CH(3), .WIDTH(8)) if2 ();
  hd_mux_rr_if #(.N_CH(1), .WIDTH(8)) if3 ();

  hd_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  hd_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  hd_mux_rr #(.N_CH(3), .WIDTH(8), .MODE(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  hd_mux_rr #(.N_CH(1), .WIDTH(8), .MODE(0)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  logic [7:0] in_a   [4][4];
  logic [3:0] in_vld [4];
  logic [1:0] in_sl  [4];
  logic       in_zr  [4];

  logic [3:0] o_rdy [4];
  logic [7:0] o_z   [4];
  logic       o_vld [4];
  logic [1:0] o_ch  [4];

  assign if0.a     = {in_a[0][3], in_a[0][2], in_a[0][1], in_a[0][0]};
  assign if0.a_vld = in_vld[0];
  assign if0.sl    = in_sl[0];
  assign if0.z_rdy = in_zr[0];
  assign if1.a     = {in_a[1][3], in_a[1][2], in_a[1][1], in_a[1][0]};
  assign if1.a_vld = in_vld[1];
  assign if1.sl    = in_sl[1];
  assign if1.z_rdy = in_zr[1];
  assign if2.a     = {in_a[2][2], in_a[2][1], in_a[2][0]};
  assign if2.a_vld = in_vld[2][2:0];
  assign if2.sl    = in_sl[2];
  assign if2.z_rdy = in_zr[2];
  assign if3.a     = in_a[3][0];
  assign if3.a_vld = in_vld[3][0];
  assign if3.sl    = in_sl[3][0];
  assign if3.z_rdy = in_zr[3];

  assign o_rdy[0] = if0.a_rdy;
  assign o_rdy[1] = if1.a_rdy;
  assign o_rdy[2] = {1'b0, if2.a_rdy};
  assign o_rdy[3] = {3'b000, if3.a_rdy};
  assign o_z[0] = if0.z;
  assign o_z[1] = if1.z;
  assign o_z[2] = if2.z;
  assign o_z[3] = if3.z;
  assign o_vld[0] = if0.z_vld;
  assign o_vld[1] = if1.z_vld;
  assign o_vld[2] = if2.z_vld;
  assign o_vld[3] = if3.z_vld;
  assign o_ch[0] = if0.z_ch;
  assign o_ch[1] = if1.z_ch;
  assign o_ch[2] = if2.z_ch;
  assign o_ch[3] = {1'b0, if3.z_ch};

  int n_of    [4] = '{4, 4, 3, 1};
  int mode_of [4] = '{0, 1, 2, 0};

  // Reference state: next channel to favour, last beat, its channel, occupancy.
  int m_ptr [4];
  int m_z   [4];
  int m_ch  [4];
  bit m_vld [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         d;
    logic [3:0] vld;
    logic       zr;
    logic [1:0] sl;
    logic [3:0] rdy;
    logic       zv;
    logic [7:0] z;
    logic [1:0] ch;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int grant(input int d);
    int n = n_of[d];
    int sel;
    if (mode_of[d] == 0) begin
      for (int k = 0; k < n; k++) begin
        if (in_vld[d][(m_ptr[d] + k) % n]) return (m_ptr[d] + k) % n;
      end
    end else if (mode_of[d] == 1) begin
      for (int c = 0; c < n; c++) begin
        if (in_vld[d][c]) return c;
      end
    end else begin
      sel = int'(in_sl[d]);
      if (sel < n && in_vld[d][sel]) return sel;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_ptr[d] = 0;
      m_z[d]   = 0;
      m_ch[d]  = 0;
      m_vld[d] = 1'b0;
    end
  endtask

  // Called shortly after a falling edge with inputs already set; runs one clock.
  task automatic cycle();
    int g  [4];
    bit xf [4];
    #1;
    for (int d = 0; d < 4; d++) begin
      g[d]  = grant(d);
      xf[d] = (!m_vld[d] || in_zr[d]) && g[d] >= 0;
      check($sformatf("a_rdy[%0d]", d), o_rdy[d], xf[d] ? (32'd1 << g[d]) : 32'd0);
    end
    @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      if (xf[d]) begin
        m_z[d]   = int'(in_a[d][g[d]]);
        m_ch[d]  = g[d];
        m_vld[d] = 1'b1;
        if (mode_of[d] == 0) m_ptr[d] = (g[d] + 1) % n_of[d];
      end else if (in_zr[d]) begin
        m_vld[d] = 1'b0;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("z_vld[%0d]", d), o_vld[d], m_vld[d]);
      check($sformatf("z[%0d]", d), o_z[d], m_z[d]);
      check($sformatf("z_ch[%0d]", d), o_ch[d], m_ch[d]);
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 4; d++) begin
      in_vld[d] = '0;
      in_zr[d]  = 1'b1;
      in_sl[d]  = '0;
    end
  endtask

  initial begin
    model_reset();
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 4; i++) in_a[d][i] = 8'h10 + 8'(i);
      in_vld[d] = 4'hf;
      in_zr[d]  = 1'b1;
      in_sl[d]  = '0;
    end

    // Reset state, with every channel requesting.
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst z_vld[%0d]", d), o_vld[d], 1'b0);
      check($sformatf("rst z[%0d]", d), o_z[d], 8'h00);
      check($sformatf("rst a_rdy[%0d]", d), o_rdy[d], 4'h0);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    idle_all();

    // d, a_vld, z_rdy, sl, expected a_rdy, then z_vld/z/z_ch after the edge.
    tbl.push_back('{0, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h10, 2'd0});
    tbl.push_back('{0, 4'b1111, 1'b1, 2'd0, 4'b0010, 1'b1, 8'h11, 2'd1});
    tbl.push_back('{0, 4'b1111, 1'b1, 2'd0, 4'b0100, 1'b1, 8'h12, 2'd2});
    tbl.push_back('{0, 4'b1111, 1'b1, 2'd0, 4'b1000, 1'b1, 8'h13, 2'd3});
    tbl.push_back('{0, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h10, 2'd0});
    tbl.push_back('{0, 4'b0010, 1'b1, 2'd0, 4'b0010, 1'b1, 8'h11, 2'd1});
    tbl.push_back('{0, 4'b1010, 1'b1, 2'd0, 4'b1000, 1'b1, 8'h13, 2'd3});
    tbl.push_back('{0, 4'b1010, 1'b1, 2'd0, 4'b0010, 1'b1, 8'h11, 2'd1});
    tbl.push_back('{0, 4'b1010, 1'b1, 2'd0, 4'b1000, 1'b1, 8'h13, 2'd3});
    tbl.push_back('{1, 4'b0110, 1'b1, 2'd0, 4'b0010, 1'b1, 8'h11, 2'd1});
    tbl.push_back('{1, 4'b0110, 1'b1, 2'd0, 4'b0010, 1'b1, 8'h11, 2'd1});
    tbl.push_back('{1, 4'b0110, 1'b1, 2'd0, 4'b0010, 1'b1, 8'h11, 2'd1});
    tbl.push_back('{2, 4'b0111, 1'b1, 2'd3, 4'b0000, 1'b0, 8'h00, 2'd0});
    tbl.push_back('{2, 4'b0111, 1'b1, 2'd2, 4'b0100, 1'b1, 8'h12, 2'd2});
    tbl.push_back('{3, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h10, 2'd0});
    tbl.push_back('{3, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h10, 2'd0});

    for (int r = 0; r < tbl.size(); r++) begin
      idle_all();
      in_vld[tbl[r].d] = tbl[r].vld;
      in_zr[tbl[r].d]  = tbl[r].zr;
      in_sl[tbl[r].d]  = tbl[r].sl;
      #1;
      check($sformatf("vec%0d a_rdy", r), o_rdy[tbl[r].d], tbl[r].rdy);
      cycle();
      check($sformatf("vec%0d z_vld", r), o_vld[tbl[r].d], tbl[r].zv);
      check($sformatf("vec%0d z", r), o_z[tbl[r].d], tbl[r].z);
      check($sformatf("vec%0d z_ch", r), o_ch[tbl[r].d], tbl[r].ch);
    end

    // Backpressure: load ch0, stall three cycles, then drain and reload together.
    idle_all();
    in_vld[0] = 4'b0001;
    cycle();
    check("bp load z", o_z[0], 8'h10);
    in_vld[0] = 4'b1111;
    in_zr[0]  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d a_rdy", i), o_rdy[0], 4'h0);
      cycle();
      check($sformatf("bp%0d z", i), o_z[0], 8'h10);
      check($sformatf("bp%0d z_ch", i), o_ch[0], 2'd0);
      check($sformatf("bp%0d z_vld", i), o_vld[0], 1'b1);
    end
    in_zr[0] = 1'b1;
    cycle();
    check("bp reload z", o_z[0], 8'h11);
    check("bp reload z_ch", o_ch[0], 2'd1);
    check("bp reload z_vld", o_vld[0], 1'b1);

    // Asynchronous reset between edges while full.
    #2 rst = 1'b1;
    #1;
    check("arst z_vld", o_vld[0], 1'b0);
    check("arst z", o_z[0], 8'h00);
    check("arst a_rdy", o_rdy[0], 4'h0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    in_vld[0] = 4'b0001;
    cycle();
    check("post rst z_ch", o_ch[0], 2'd0);
    check("post rst z_vld", o_vld[0], 1'b1);
    check("post rst z", o_z[0], 8'h10);

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 4; d++) begin
        for (int i = 0; i < 4; i++) in_a[d][i] = 8'($urandom_range(0, 255));
        in_vld[d] = 4'($urandom_range(0, 15));
        in_zr[d]  = ($urandom_range(0, 3) != 0);
        in_sl[d]  = 2'($urandom_range(0, 3));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
